pb_debounce_ctrl: RTL and testbench

Front-end conditioning stage for the board push buttons, directly upstream of the counter/display control logic. It generates its own 1 kHz sampling tick from the 50 MHz clock and debounces each active-low button with a shift register. Per button it emits a debounced level, a one-cycle press pulse and a one-cycle release pulse, so downstream stages never perform their own edge detection. An optional auto-repeat generates extra press pulses while a button is held.

---
 rtl/pb_pkg.sv | 17 +
 rtl/pb_debounce_ctrl_if.sv | 28 ++
 rtl/pb_debounce_channel.sv | 112 +++++++++++
 rtl/pb_debounce_ctrl.sv | 83 ++++++++
 tb/tb_pb_debounce_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pb_pkg.sv
// Shared types and defaults for the push-button conditioning block.
package pb_pkg;

   localparam int PB_NUM_PB_DEF = 4;
   localparam int PB_DEPTH_DEF  = 10;

   typedef enum logic [1:0] {
      PB_IDLE,
      PB_HOLD,
      PB_REPEAT
   } pb_state_t;

   function automatic int pb_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pb_debounce_ctrl_if.sv
// Button-side bundle: sampling strobe and raw inputs in, conditioned level and pulses out.
interface pb_debounce_ctrl_if #(
   parameter int N = 1
);

   logic         tick;
   logic [N-1:0] btn_n;
   logic [N-1:0] level;
   logic [N-1:0] press;
   logic [N-1:0] rel;

   modport master (
      output tick,
      output btn_n,
      input  level,
      input  press,
      input  rel
   );

   modport slave (
      input  tick,
      input  btn_n,
      output level,
      output press,
      output rel
   );

endinterface

// File: rtl/pb_debounce_channel.sv
// One button: tick-sampled shift-register debounce, press/release pulses and,
// with PB_AUTO_REPEAT_EN defined, an auto-repeat FSM with a saturating hold counter.
module pb_debounce_channel
   import pb_pkg::*;
#(
`ifdef PB_AUTO_REPEAT_EN
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100,
`endif
   parameter int DEPTH = PB_DEPTH_DEF
) (
   input logic                 clk,
   input logic                 rst_n,
   pb_debounce_ctrl_if.slave   ch_if
);

   logic [DEPTH-1:0] sh_q, sh_d;
   logic             level_q, press_q, rel_q;
   logic             level_d, rise, fall, press_d;

   always_comb begin
      sh_d = sh_q;
      if (ch_if.tick) begin
         sh_d = {sh_q[DEPTH-2:0], ~ch_if.btn_n[0]};
      end
   end

   // Any pressed sample in the window holds the level: fast press, slow release.
   assign level_d = |sh_q;
   assign rise    = level_d & ~level_q;
   assign fall    = ~level_d & level_q;

`ifdef PB_AUTO_REPEAT_EN
   localparam int                CW       = $clog2(pb_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [CW-1:0]     DELAY_C  = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0]     PERIOD_C = CW'(REPEAT_PERIOD);

   pb_state_t     state_q, state_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic          repeat_d;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      repeat_d   = 1'b0;
      if (ch_if.tick && (hold_cnt_q != '1)) begin
         hold_cnt_d = hold_cnt_q + 1'b1;
      end
      unique case (state_q)
         PB_IDLE: begin
            hold_cnt_d = '0;
            if (rise) state_d = PB_HOLD;
         end
         PB_HOLD: begin
            if (hold_cnt_q == DELAY_C) begin
               repeat_d   = 1'b1;
               hold_cnt_d = '0;
               state_d    = PB_REPEAT;
            end
         end
         PB_REPEAT: begin
            if (hold_cnt_q == PERIOD_C) begin
               repeat_d   = 1'b1;
               hold_cnt_d = '0;
            end
         end
         default: state_d = PB_IDLE;
      endcase
      // Release wins so press and release never share a cycle.
      if (fall) begin
         state_d    = PB_IDLE;
         hold_cnt_d = '0;
         repeat_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PB_IDLE;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign press_d = rise | repeat_d;
`else
   assign press_d = rise;
`endif

   // NOTE: the shift register is cleared on reset like any other state, so a
   // button held through reset is seen as a fresh press on the first tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q    <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= fall;
      end
   end

   assign ch_if.level = level_q;
   assign ch_if.press = press_q;
   assign ch_if.rel   = rel_q;

endmodule

// File: rtl/pb_debounce_ctrl.sv
// Push-button front end: 1 kHz tick generator plus NUM_PB debounce channels.
// Define PB_AUTO_REPEAT_EN to build the auto-repeat FSMs.
module pb_debounce_ctrl
   import pb_pkg::*;
#(
   parameter int DIV_COUNT     = 50000,
   parameter int DEPTH         = PB_DEPTH_DEF,
   parameter int NUM_PB        = PB_NUM_PB_DEF,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic              CLOCK_50_I,
   input  logic              resetn,
   input  logic [NUM_PB-1:0] PUSH_BUTTON_I,
   output logic [NUM_PB-1:0] pb_level_o,
   output logic [NUM_PB-1:0] pb_press_o,
   output logic [NUM_PB-1:0] pb_release_o,
   output logic              tick_o
);

   if (DIV_COUNT < 2) begin : g_bad_div
      $error("DIV_COUNT must be at least 2");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("DEPTH must be at least 2");
   end
   if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_repeat
      $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
   end

   localparam int               CNT_W    = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // NOTE: every signal gets a default before any branch so no latch is inferred.
   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      tick_d = 1'b0;
      if (cnt_q == CNT_LAST) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   // NOTE: state updates use non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

   for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
      pb_debounce_ctrl_if #(.N(1)) ch_if ();

      assign ch_if.tick      = tick_q;
      assign ch_if.btn_n     = PUSH_BUTTON_I[i];
      assign pb_level_o[i]   = ch_if.level;
      assign pb_press_o[i]   = ch_if.press;
      assign pb_release_o[i] = ch_if.rel;

      pb_debounce_channel #(
`ifdef PB_AUTO_REPEAT_EN
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD),
`endif
         .DEPTH         (DEPTH)
      ) u_ch (
         .clk   (CLOCK_50_I),
         .rst_n (resetn),
         .ch_if (ch_if)
      );
   end

endmodule

// File: tb/tb_pb_debounce_ctrl.sv
// Directed bench for pb_debounce_ctrl: DIV_COUNT=4, DEPTH=10, REPEAT_DELAY=5, REPEAT_PERIOD=2.
module tb_pb_debounce_ctrl;

   localparam int NB = 4;

`ifdef PB_AUTO_REPEAT_EN
   localparam logic [3:0] R = 4'h4;
`else
   localparam logic [3:0] R = 4'h0;
`endif

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   pb_debounce_ctrl_if #(.N(NB)) pb_if ();

   pb_debounce_ctrl #(
      .DIV_COUNT     (4),
      .DEPTH         (10),
      .NUM_PB        (NB),
      .REPEAT_DELAY  (5),
      .REPEAT_PERIOD (2)
   ) dut (
      .CLOCK_50_I    (clk),
      .resetn        (resetn),
      .PUSH_BUTTON_I (pb_if.btn_n),
      .pb_level_o    (pb_if.level),
      .pb_press_o    (pb_if.press),
      .pb_release_o  (pb_if.rel),
      .tick_o        (pb_if.tick)
   );

   always #5 clk = ~clk;

   // Cycle index: cycle c is the interval after the c-th rising edge since reset release.
   int cyc = 0;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   int press_cnt [NB];
   int rel_cnt   [NB];
   int overlap_cnt = 0;

   always @(negedge clk) begin
      if (resetn) begin
         for (int i = 0; i < NB; i++) begin
            if (pb_if.press[i]) press_cnt[i] <= press_cnt[i] + 1;
            if (pb_if.rel[i])   rel_cnt[i]   <= rel_cnt[i] + 1;
         end
         if ((pb_if.press & pb_if.rel) != '0) overlap_cnt <= overlap_cnt + 1;
      end
   end

   typedef struct {
      int         cyc;
      logic [3:0] btn_n;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
   } vec_t;

   vec_t vecs [$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   function automatic void add_vec(input int c, input logic [3:0] b, input logic [3:0] l,
                                   input logic [3:0] p, input logic [3:0] r);
      vec_t v;
      v.cyc = c; v.btn_n = b; v.lvl = l; v.prs = p; v.rel = r;
      vecs.push_back(v);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int snap;

      // Ticks on cycles 4k; sample k lands in the level/pulses at cycle 4k+2.
      // Columns: cycle, buttons from this cycle on, expected level, press, release.
      add_vec( 13, 4'hE, 4'h0, 4'h0, 4'h0);  // PB0 pressed, sampled on tick 4
      add_vec( 17, 4'hE, 4'h0, 4'h0, 4'h0);
      add_vec( 18, 4'hE, 4'h1, 4'h1, 4'h0);
      add_vec( 19, 4'hE, 4'h1, 4'h0, 4'h0);
      add_vec( 21, 4'hF, 4'h1, 4'h0, 4'h0);  // last pressed sample: tick 5
      add_vec( 61, 4'hF, 4'h1, 4'h0, 4'h0);
      add_vec( 62, 4'hF, 4'h0, 4'h0, 4'h1);  // tick 15 + 2
      add_vec( 63, 4'hF, 4'h0, 4'h0, 4'h0);
      add_vec( 65, 4'hE, 4'h0, 4'h0, 4'h0);  // second press, tick 17
      add_vec( 70, 4'hE, 4'h1, 4'h1, 4'h0);
      add_vec( 71, 4'hE, 4'h1, 4'h0, 4'h0);
      add_vec( 73, 4'hF, 4'h1, 4'h0, 4'h0);  // released after tick 18
      add_vec( 81, 4'hE, 4'h1, 4'h0, 4'h0);  // bounce: pressed on tick 21
      add_vec( 85, 4'hF, 4'h1, 4'h0, 4'h0);
      add_vec( 86, 4'hF, 4'h1, 4'h0, 4'h0);
      add_vec( 89, 4'hE, 4'h1, 4'h0, 4'h0);  // bounce: pressed on tick 23
      add_vec( 93, 4'hF, 4'h1, 4'h0, 4'h0);
      add_vec( 94, 4'hF, 4'h1, 4'h0, 4'h0);
      add_vec(114, 4'hF, 4'h1, 4'h0, 4'h0);  // would have released without bounce
      add_vec(133, 4'hF, 4'h1, 4'h0, 4'h0);
      add_vec(134, 4'hF, 4'h0, 4'h0, 4'h1);  // tick 33 + 2
      add_vec(135, 4'hF, 4'h0, 4'h0, 4'h0);
      add_vec(141, 4'h5, 4'h0, 4'h0, 4'h0);  // PB1 and PB3 together, tick 36
      add_vec(145, 4'h5, 4'h0, 4'h0, 4'h0);
      add_vec(146, 4'h5, 4'hA, 4'hA, 4'h0);
      add_vec(147, 4'h5, 4'hA, 4'h0, 4'h0);
      add_vec(149, 4'hF, 4'hA, 4'h0, 4'h0);  // last pressed sample: tick 37
      add_vec(189, 4'hF, 4'hA, 4'h0, 4'h0);
      add_vec(190, 4'hF, 4'h0, 4'h0, 4'hA);
      add_vec(191, 4'hF, 4'h0, 4'h0, 4'h0);
      add_vec(197, 4'hB, 4'h0, 4'h0, 4'h0);  // PB2 held, hold tick 0 = tick 50
      add_vec(202, 4'hB, 4'h4, 4'h4, 4'h0);
      add_vec(203, 4'hB, 4'h4, 4'h0, 4'h0);
      add_vec(222, 4'hB, 4'h4, R,    4'h0);  // hold tick 5
      add_vec(223, 4'hB, 4'h4, 4'h0, 4'h0);
      add_vec(230, 4'hB, 4'h4, R,    4'h0);  // hold tick 7
      add_vec(238, 4'hB, 4'h4, R,    4'h0);  // hold tick 9
      add_vec(245, 4'hF, 4'h4, 4'h0, 4'h0);  // 12 pressed samples taken
      add_vec(246, 4'hF, 4'h4, R,    4'h0);  // hold tick 11
      add_vec(285, 4'hF, 4'h4, 4'h0, 4'h0);
      add_vec(286, 4'hF, 4'h0, 4'h0, 4'h4);  // release beats a coincident repeat
      add_vec(287, 4'hF, 4'h0, 4'h0, 4'h0);
      add_vec(293, 4'hB, 4'h0, 4'h0, 4'h0);  // PB2 again, tick 74
      add_vec(298, 4'hB, 4'h4, 4'h4, 4'h0);

      // Reset with all buttons pressed.
      pb_if.btn_n = 4'h0;
      resetn      = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_level",   32'(pb_if.level), 32'h0);
      check("reset_press",   32'(pb_if.press), 32'h0);
      check("reset_release", 32'(pb_if.rel),   32'h0);
      check("reset_tick",    32'(pb_if.tick),  32'h0);
      pb_if.btn_n = 4'hF;
      resetn      = 1'b1;

      for (int c = 1; c <= 12; c++) begin
         wait_cyc(c);
         check($sformatf("tick_c%0d", c), 32'(pb_if.tick), 32'((c % 4) == 0));
      end

      for (int i = 0; i < vecs.size(); i++) begin
         wait_cyc(vecs[i].cyc);
         check($sformatf("level_c%0d",   vecs[i].cyc), 32'(pb_if.level), 32'(vecs[i].lvl));
         check($sformatf("press_c%0d",   vecs[i].cyc), 32'(pb_if.press), 32'(vecs[i].prs));
         check($sformatf("release_c%0d", vecs[i].cyc), 32'(pb_if.rel),   32'(vecs[i].rel));
         pb_if.btn_n = vecs[i].btn_n;
      end

      check("pb0_press_count",   32'(press_cnt[0]), 32'd2);
      check("pb0_release_count", 32'(rel_cnt[0]),   32'd2);
      check("pb1_press_count",   32'(press_cnt[1]), 32'd1);
      check("pb1_release_count", 32'(rel_cnt[1]),   32'd1);
      check("pb3_press_count",   32'(press_cnt[3]), 32'd1);
      check("pb3_release_count", 32'(rel_cnt[3]),   32'd1);
      check("press_release_overlap", 32'(overlap_cnt), 32'd0);

      // Reset while PB2 is held: outputs clear at once, no release pulse follows.
      wait_cyc(320);
      check("hold_level_before_reset", 32'(pb_if.level), 32'h4);
      snap        = rel_cnt[2];
      resetn      = 1'b0;
      pb_if.btn_n = 4'hF;
      #1;
      check("midhold_reset_level",   32'(pb_if.level), 32'h0);
      check("midhold_reset_press",   32'(pb_if.press), 32'h0);
      check("midhold_reset_release", 32'(pb_if.rel),   32'h0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (60) @(negedge clk);
      check("no_trailing_release", 32'(rel_cnt[2]), 32'(snap));
      check("level_after_reset",   32'(pb_if.level), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
